// File: rtl/instr_prefetch_unit_if.sv
// instr_prefetch_unit_if: instruction type package and instruction memory request/response bus
package instr_prefetch_pkg;
  typedef enum logic {NONE, UNKNOWN} instr_type_t;
endpackage

interface instr_prefetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: multi-outstanding in-order instruction prefetcher with a PC-tagged queue
// Define IFETCH_PERF_CNT_EN to add perf_fetch_cnt / perf_drop_cnt outputs.
module instr_prefetch_unit
  import instr_prefetch_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         jmp,
  input  logic [31:0]                  jmp_addr,
  output logic                         out_valid,
  output logic [31:0]                  out_addr,
  output logic [31:0]                  out_instr,
  output instr_type_t                  out_instr_type,
  instr_prefetch_unit_if.master        mem
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_fetch_cnt,
  output logic [31:0]                  perf_drop_cnt
`endif
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (OW > CW ? OW : CW) + 1;
  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};
  logic [31:0]   fetch_pc, rsp_pc, jmp_pc;
  logic [OW-1:0] outstanding, drop_cnt, left_after_rsp;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   addr_q [FIFO_DEPTH];
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [SW-1:0] credit_used;
  logic          req_fire, push, pop, rsp_drop;
  // queue slots are reserved at issue time, so in-flight plus queued never exceeds the depth
  assign credit_used    = SW'(outstanding) + SW'(count);
  assign mem.req_valid  = rst_n && !jmp && outstanding < OW'(MAX_OUTSTANDING) && credit_used < SW'(FIFO_DEPTH);
  assign mem.req_addr   = fetch_pc;
  assign jmp_pc         = jmp_addr & 32'hFFFF_FFFC;
  assign req_fire       = mem.req_valid && mem.req_ready;
  assign push           = mem.rsp_valid && !jmp && drop_cnt == '0;
  assign rsp_drop       = mem.rsp_valid && !push;
  assign left_after_rsp = outstanding - OW'(mem.rsp_valid);
  assign out_valid      = count != '0;
  assign pop            = out_valid && !stall && !jmp;
  assign out_addr       = addr_q[rd_ptr];
  assign out_instr      = data_q[rd_ptr];
  assign out_instr_type = out_valid ? UNKNOWN : NONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc    <= RST_PC;
      rsp_pc      <= RST_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (jmp) begin
      fetch_pc    <= jmp_pc;
      rsp_pc      <= jmp_pc;
      outstanding <= left_after_rsp;
      drop_cnt    <= left_after_rsp;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      fetch_pc    <= fetch_pc + (req_fire ? 32'd4 : 32'd0);
      rsp_pc      <= rsp_pc + (push ? 32'd4 : 32'd0);
      outstanding <= outstanding + OW'(req_fire) - OW'(mem.rsp_valid);
      drop_cnt    <= drop_cnt - OW'(rsp_drop);
      count       <= count + CW'(push) - CW'(pop);
      wr_ptr      <= wr_ptr + AW'(push);
      rd_ptr      <= rd_ptr + AW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      addr_q[wr_ptr] <= rsp_pc;
      data_q[wr_ptr] <= mem.rsp_data;
    end
`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(req_fire);
      perf_drop_cnt  <= perf_drop_cnt + 32'(rsp_drop);
    end
`endif
endmodule
